// File: rtl/execute_stage.sv
// Execute stage: decode/execute pipeline register, forwarding muxes,
// and combinational 8-bit scalar plus 16-lane vector ALUs.
module execute_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [19:0]  nop_mux_output_in,
  input  logic [15:0]  srcA_in,
  input  logic [15:0]  srcB_in,
  input  logic [127:0] srcA_vector_in,
  input  logic [127:0] srcB_vector_in,
  input  logic [4:0]   rs1_decode,
  input  logic [4:0]   rs2_decode,
  input  logic [4:0]   rd_decode,
  input  logic [2:0]   select_forward_mux_A,
  input  logic [2:0]   select_forward_mux_B,
  input  logic [15:0]  writeback_data,
  input  logic [15:0]  alu_result_memory,
  input  logic [127:0] writeback_vector,
  input  logic [127:0] alu_vector_result_memory,
  output logic         wre_execute,
  output logic         vector_wre_execute,
  output logic         write_memory_enable_a_execute,
  output logic         write_memory_enable_b_execute,
  output logic         load_instruction,
  output logic [1:0]   select_writeback_data_mux_execute,
  output logic [1:0]   select_writeback_vector_data_mux_execute,
  output logic [4:0]   aluOp_execute,
  output logic [4:0]   aluVectorOp_execute,
  output logic [15:0]  srcA_out,
  output logic [15:0]  srcB_out,
  output logic [127:0] srcA_vector_out,
  output logic [127:0] srcB_vector_out,
  output logic [4:0]   rs1_execute,
  output logic [4:0]   rs2_execute,
  output logic [4:0]   rd_execute,
  output logic [15:0]  alu_src_A,
  output logic [15:0]  alu_src_B,
  output logic [127:0] alu_src_vector_A,
  output logic [127:0] alu_src_vector_B,
  output logic [7:0]   alu_result_execute,
  output logic [127:0] alu_vector_result_execute
);

  logic [18:0]  ctrl_d, ctrl_q;
  logic [15:0]  src_a_d, src_a_q;
  logic [15:0]  src_b_d, src_b_q;
  logic [127:0] vec_a_d, vec_a_q;
  logic [127:0] vec_b_d, vec_b_q;
  logic [4:0]   rs1_d, rs1_q;
  logic [4:0]   rs2_d, rs2_q;
  logic [4:0]   rd_d, rd_q;

  // Bit 19 of the control word is reserved and never stored.
  always_comb begin
    ctrl_d  = nop_mux_output_in[18:0];
    src_a_d = srcA_in;
    src_b_d = srcB_in;
    vec_a_d = srcA_vector_in;
    vec_b_d = srcB_vector_in;
    rs1_d   = rs1_decode;
    rs2_d   = rs2_decode;
    rd_d    = rd_decode;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      vec_a_q <= '0;
      vec_b_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign aluOp_execute       = ctrl_q[4:0];
  assign aluVectorOp_execute = ctrl_q[9:5];
  assign load_instruction    = ctrl_q[10];
  assign select_writeback_vector_data_mux_execute = ctrl_q[12:11];
  assign select_writeback_data_mux_execute        = ctrl_q[14:13];
  assign write_memory_enable_b_execute = ctrl_q[15];
  assign write_memory_enable_a_execute = ctrl_q[16];
  assign vector_wre_execute  = ctrl_q[17];
  assign wre_execute         = ctrl_q[18];

  assign srcA_out        = src_a_q;
  assign srcB_out        = src_b_q;
  assign srcA_vector_out = vec_a_q;
  assign srcB_vector_out = vec_b_q;
  assign rs1_execute     = rs1_q;
  assign rs2_execute     = rs2_q;
  assign rd_execute      = rd_q;

  function automatic logic [15:0] fwd16(
    input logic [2:0]  sel,
    input logic [15:0] r,
    input logic [15:0] wb,
    input logic [15:0] mem
  );
    unique case (1'b1)
      (sel == 3'd1): fwd16 = wb;
      (sel == 3'd2): fwd16 = mem;
      default:       fwd16 = r;
    endcase
  endfunction

  function automatic logic [127:0] fwd128(
    input logic [2:0]   sel,
    input logic [127:0] r,
    input logic [127:0] wb,
    input logic [127:0] mem
  );
    unique case (1'b1)
      (sel == 3'd1): fwd128 = wb;
      (sel == 3'd2): fwd128 = mem;
      default:       fwd128 = r;
    endcase
  endfunction

  function automatic logic [7:0] alu8(
    input logic [4:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      5'd0:    alu8 = a + b;
      5'd1:    alu8 = a - b;
      5'd2:    alu8 = a & b;
      5'd3:    alu8 = a | b;
      5'd4:    alu8 = a ^ b;
      5'd5:    alu8 = a << b[2:0];
      5'd6:    alu8 = a >> b[2:0];
      5'd7:    alu8 = a * b;
      5'd8:    alu8 = b;
      default: alu8 = 8'h00;
    endcase
  endfunction

  always_comb begin
    alu_src_A = fwd16(select_forward_mux_A, src_a_q,
                      writeback_data, alu_result_memory);
    alu_src_B = fwd16(select_forward_mux_B, src_b_q,
                      writeback_data, alu_result_memory);
    alu_src_vector_A = fwd128(select_forward_mux_A, vec_a_q,
                              writeback_vector,
                              alu_vector_result_memory);
    alu_src_vector_B = fwd128(select_forward_mux_B, vec_b_q,
                              writeback_vector,
                              alu_vector_result_memory);
  end

  always_comb begin
    alu_result_execute = alu8(aluOp_execute, alu_src_A[7:0],
                              alu_src_B[7:0]);
  end

  // Lanes are fully independent: no carry or borrow crosses a byte.
  always_comb begin
    alu_vector_result_execute = '0;
    for (int i = 0; i < 16; i++) begin
      alu_vector_result_execute[8*i +: 8] =
        alu8(aluVectorOp_execute,
             alu_src_vector_A[8*i +: 8],
             alu_src_vector_B[8*i +: 8]);
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expectations,
// a monitor pops and compares one entry per clock.
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [19:0]  nop_mux_output_in;
  logic [15:0]  srcA_in, srcB_in;
  logic [127:0] srcA_vector_in, srcB_vector_in;
  logic [4:0]   rs1_decode, rs2_decode, rd_decode;
  logic [2:0]   select_forward_mux_A, select_forward_mux_B;
  logic [15:0]  writeback_data, alu_result_memory;
  logic [127:0] writeback_vector, alu_vector_result_memory;
  logic         wre_execute, vector_wre_execute;
  logic         write_memory_enable_a_execute;
  logic         write_memory_enable_b_execute, load_instruction;
  logic [1:0]   select_writeback_data_mux_execute;
  logic [1:0]   select_writeback_vector_data_mux_execute;
  logic [4:0]   aluOp_execute, aluVectorOp_execute;
  logic [15:0]  srcA_out, srcB_out;
  logic [127:0] srcA_vector_out, srcB_vector_out;
  logic [4:0]   rs1_execute, rs2_execute, rd_execute;
  logic [15:0]  alu_src_A, alu_src_B;
  logic [127:0] alu_src_vector_A, alu_src_vector_B;
  logic [7:0]   alu_result_execute;
  logic [127:0] alu_vector_result_execute;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .nop_mux_output_in(nop_mux_output_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in),
    .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
    .rd_decode(rd_decode),
    .select_forward_mux_A(select_forward_mux_A),
    .select_forward_mux_B(select_forward_mux_B),
    .writeback_data(writeback_data),
    .alu_result_memory(alu_result_memory),
    .writeback_vector(writeback_vector),
    .alu_vector_result_memory(alu_vector_result_memory),
    .wre_execute(wre_execute),
    .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_a_execute(write_memory_enable_a_execute),
    .write_memory_enable_b_execute(write_memory_enable_b_execute),
    .load_instruction(load_instruction),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .select_writeback_vector_data_mux_execute(
      select_writeback_vector_data_mux_execute),
    .aluOp_execute(aluOp_execute),
    .aluVectorOp_execute(aluVectorOp_execute),
    .srcA_out(srcA_out), .srcB_out(srcB_out),
    .srcA_vector_out(srcA_vector_out),
    .srcB_vector_out(srcB_vector_out),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute),
    .rd_execute(rd_execute),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .alu_src_vector_A(alu_src_vector_A),
    .alu_src_vector_B(alu_src_vector_B),
    .alu_result_execute(alu_result_execute),
    .alu_vector_result_execute(alu_vector_result_execute)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [31:0]  ctrl;
    logic [255:0] sregs;
    logic [255:0] vregs;
    logic [14:0]  idx;
    logic [31:0]  fs;
    logic [255:0] fv;
    logic [7:0]   res;
    logic [127:0] vres;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  string cur_name = "init";

  function automatic int ref_alu(int op, int a, int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * (1 << (b % 8))) % 256;
      6: return a / (1 << (b % 8));
      7: return (a * b) % 256;
      8: return b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [127:0] ref_pick(int sel, logic [127:0] r,
                                            logic [127:0] wb,
                                            logic [127:0] mem);
    if (sel == 1) return wb;
    if (sel == 2) return mem;
    return r;
  endfunction

  task automatic chk(string nm, logic [255:0] got, logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", cur_name, nm, got, want);
    end
  endtask

  // Expected response for the transaction driven right now.
  task automatic step(string nm);
    exp_t e;
    logic [127:0] ra, rb, va, vb, fa, fb, fva, fvb;
    int op, vop;
    logic [4:0] f_op, f_vop;
    e.name = nm;
    if (reset) begin
      f_op  = nop_mux_output_in[4:0];
      f_vop = nop_mux_output_in[9:5];
      e.ctrl = {13'd0,
                nop_mux_output_in[18], nop_mux_output_in[17],
                nop_mux_output_in[16], nop_mux_output_in[15],
                nop_mux_output_in[14:13], nop_mux_output_in[12:11],
                nop_mux_output_in[10], f_vop, f_op};
      ra = {112'd0, srcA_in};
      rb = {112'd0, srcB_in};
      va = srcA_vector_in;
      vb = srcB_vector_in;
      e.idx = {rs1_decode, rs2_decode, rd_decode};
    end else begin
      f_op = 0; f_vop = 0;
      e.ctrl = 0; ra = 0; rb = 0; va = 0; vb = 0; e.idx = 0;
    end
    op = f_op;
    vop = f_vop;
    e.sregs = {96'd0, ra[15:0], rb[15:0], 128'd0};
    e.vregs = {va, vb};
    fa = ref_pick(select_forward_mux_A, ra, {112'd0, writeback_data},
                  {112'd0, alu_result_memory});
    fb = ref_pick(select_forward_mux_B, rb, {112'd0, writeback_data},
                  {112'd0, alu_result_memory});
    fva = ref_pick(select_forward_mux_A, va, writeback_vector,
                   alu_vector_result_memory);
    fvb = ref_pick(select_forward_mux_B, vb, writeback_vector,
                   alu_vector_result_memory);
    e.fs = {fa[15:0], fb[15:0]};
    e.fv = {fva, fvb};
    e.res = 8'(ref_alu(op, int'(fa[7:0]), int'(fb[7:0])));
    for (int l = 0; l < 16; l++)
      e.vres[8*l +: 8] = 8'(ref_alu(vop, int'(fva[8*l +: 8]),
                                    int'(fvb[8*l +: 8])));
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cur_name = e.name;
        chk("ctrl", {13'd0, wre_execute, vector_wre_execute,
                     write_memory_enable_a_execute,
                     write_memory_enable_b_execute,
                     select_writeback_data_mux_execute,
                     select_writeback_vector_data_mux_execute,
                     load_instruction, aluVectorOp_execute,
                     aluOp_execute}, {224'd0, e.ctrl});
        chk("sregs", {96'd0, srcA_out, srcB_out, 128'd0}, e.sregs);
        chk("vregs", {srcA_vector_out, srcB_vector_out}, e.vregs);
        chk("idx", {241'd0, rs1_execute, rs2_execute, rd_execute},
            {241'd0, e.idx});
        chk("fwd_s", {224'd0, alu_src_A, alu_src_B}, {224'd0, e.fs});
        chk("fwd_v", {alu_src_vector_A, alu_src_vector_B}, e.fv);
        chk("alu", {248'd0, alu_result_execute}, {248'd0, e.res});
        chk("valu", {128'd0, alu_vector_result_execute},
            {128'd0, e.vres});
      end
    end
  end

  task automatic clear_inputs();
    nop_mux_output_in = 0;
    srcA_in = 0; srcB_in = 0;
    srcA_vector_in = 0; srcB_vector_in = 0;
    rs1_decode = 0; rs2_decode = 0; rd_decode = 0;
    select_forward_mux_A = 0; select_forward_mux_B = 0;
    writeback_data = 0; alu_result_memory = 0;
    writeback_vector = 0; alu_vector_result_memory = 0;
  endtask

  task automatic set_ops(int op, int vop);
    nop_mux_output_in = 20'((vop << 5) | op);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);

    nop_mux_output_in = 20'h7FFFF;
    srcA_in = 16'h1234; srcB_in = 16'h5678;
    srcA_vector_in = {16{8'hAA}}; srcB_vector_in = {16{8'h55}};
    rs1_decode = 7; rs2_decode = 9; rd_decode = 31;
    step("reset0");
    step("reset1");

    reset = 1'b1;
    clear_inputs();
    nop_mux_output_in = 20'b00000000000010100000;
    srcA_in = 1; srcB_in = 2;
    srcA_vector_in = 128'd1; srcB_vector_in = 128'd1;
    rs1_decode = 1; rs2_decode = 2; rd_decode = 3;
    step("capture");

    for (int op = 0; op < 10; op++) begin
      clear_inputs();
      set_ops(op, op);
      srcA_in = 16'h00F0; srcB_in = 16'h0013;
      srcA_vector_in = {16{8'hF0}}; srcB_vector_in = {16{8'h13}};
      step($sformatf("sweep%0d", op));
    end

    clear_inputs();
    set_ops(0, 0);
    srcA_vector_in = {16{8'hFF}}; srcB_vector_in = {16{8'h01}};
    step("vec_nocarry");
    clear_inputs();
    set_ops(1, 1);
    srcA_vector_in = 0; srcB_vector_in = {16{8'h01}};
    step("vec_noborrow");

    clear_inputs();
    srcA_in = 16'h0033; srcB_in = 2;
    select_forward_mux_A = 1; writeback_data = 16'h0005;
    step("fwd_wb");
    clear_inputs();
    srcA_in = 16'h0033; srcB_in = 2;
    select_forward_mux_A = 2; alu_result_memory = 16'h0009;
    step("fwd_mem");
    clear_inputs();
    srcA_in = 16'h0033; srcB_in = 2;
    select_forward_mux_A = 3; writeback_data = 5;
    alu_result_memory = 9;
    step("fwd_sel3");

    for (int b = 10; b < 20; b++) begin
      clear_inputs();
      nop_mux_output_in = 20'(1 << b);
      step($sformatf("field%0d", b));
    end

    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 19) != 0);
      nop_mux_output_in = 20'($urandom);
      if ($urandom_range(0, 1) == 1)
        nop_mux_output_in[4:0] = 5'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1)
        nop_mux_output_in[9:5] = 5'($urandom_range(0, 9));
      srcA_in = 16'($urandom); srcB_in = 16'($urandom);
      srcA_vector_in = rand128(); srcB_vector_in = rand128();
      rs1_decode = 5'($urandom); rs2_decode = 5'($urandom);
      rd_decode = 5'($urandom);
      select_forward_mux_A = 3'($urandom);
      select_forward_mux_B = 3'($urandom);
      writeback_data = 16'($urandom);
      alu_result_memory = {8'd0, 8'($urandom)};
      writeback_vector = rand128();
      alu_vector_result_memory = rand128();
      step("random");
    end

    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    cur_name = "end";
    chk("drain", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
